// File: rtl/mycpu_exe_stage.sv
// ---------------------------------------------------------------------------
// mycpu_exe_stage : execute stage of a 5-stage MIPS-style pipeline.
//
// Holds one instruction (es_valid plus latched decode fields), runs it through
// myCPU_alu, owns the HI/LO register pair (MULT/MULTU/MTHI/MTLO and, when the
// divider is compiled in, DIV/DIVU), and hands the result to the memory stage
// with a valid/allowin handshake.
//
// Build option:
//   MYCPU_DIV_EN  defined   -> 32-iteration restoring divider (IDLE/BUSY/DONE)
//                 undefined -> DIV/DIVU complete in one cycle as no-ops
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ds_to_es_valid        decode offers an instruction
//   es_allowin            this stage can accept an instruction
//   ds_aluop/src1/src2    ALU opcode and operands A, B
//   ds_md_op              1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   ds_res_sel            0 ALU, 1 HI, 2 LO, 3 zero
//   ds_ov_chk             overflow traps for this instruction
//   ds_dest, ds_pc        destination register, instruction PC
//   flush                 kill the instruction in EX
//   ms_allowin            memory stage can accept
//   es_to_ms_valid        result offered downstream
//   es_result/dest/pc/ex  result, destination (0 = no writeback), PC, overflow
//
// ALU opcodes: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR,
//              8 SLL, 9 SRL, 10 SRA (B shifted by A[4:0]), 11 LUI (B[15:0]<<16)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module myCPU_alu (
  input  logic [3:0]  aluop,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] aluResult,
  output logic        overFlow
);
  // One extra sign bit makes signed overflow and signed compare trivial.
  logic [32:0] w_sum;
  logic [32:0] w_dif;

  assign w_sum = {src1[31], src1} + {src2[31], src2};
  assign w_dif = {src1[31], src1} - {src2[31], src2};

  always_comb begin
    aluResult = 32'd0;
    overFlow  = 1'b0;
    case (aluop)
      4'd0: begin
        aluResult = w_sum[31:0];
        overFlow  = w_sum[32] ^ w_sum[31];
      end
      4'd1: begin
        aluResult = w_dif[31:0];
        overFlow  = w_dif[32] ^ w_dif[31];
      end
      4'd2:  aluResult = {31'd0, w_dif[32]};
      4'd3:  aluResult = {31'd0, (src1 < src2)};
      4'd4:  aluResult = src1 & src2;
      4'd5:  aluResult = src1 | src2;
      4'd6:  aluResult = src1 ^ src2;
      4'd7:  aluResult = ~(src1 | src2);
      4'd8:  aluResult = src2 << src1[4:0];
      4'd9:  aluResult = src2 >> src1[4:0];
      4'd10: aluResult = $signed(src2) >>> src1[4:0];
      4'd11: aluResult = {src2[15:0], 16'd0};
      default: aluResult = 32'd0;
    endcase
  end
endmodule

module mycpu_exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [3:0]  ds_aluop,
  input  logic [31:0] ds_src1,
  input  logic [31:0] ds_src2,
  input  logic [2:0]  ds_md_op,
  input  logic [1:0]  ds_res_sel,
  input  logic        ds_ov_chk,
  input  logic [4:0]  ds_dest,
  input  logic [31:0] ds_pc,
  input  logic        flush,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_result,
  output logic [4:0]  es_dest,
  output logic [31:0] es_pc,
  output logic        es_ex
);
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  logic        r_es_valid;
  logic [3:0]  r_aluop;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [2:0]  r_md_op;
  logic [1:0]  r_res_sel;
  logic        r_ov_chk;
  logic [4:0]  r_dest;
  logic [31:0] r_pc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_alu_result;
  logic        w_alu_ov;
  logic        w_ready_go;
  logic        w_ex;
  logic        w_handshake;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_hi_next;
  logic [31:0] w_lo_next;

  myCPU_alu u_alu (
    .aluop     (r_aluop),
    .src1      (r_src1),
    .src2      (r_src2),
    .aluResult (w_alu_result),
    .overFlow  (w_alu_ov)
  );

  // ---------------- handshake ----------------
  assign w_ex           = r_es_valid & r_ov_chk & w_alu_ov;
  assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
  // Reset gating keeps outputs quiet even in the first reset cycle.
  assign es_to_ms_valid = r_es_valid & w_ready_go & ~flush & ~reset;
  assign w_handshake    = es_to_ms_valid & ms_allowin;
  assign es_ex          = w_ex & ~reset;
  assign es_dest        = (r_es_valid & ~w_ex & ~reset) ? r_dest : 5'd0;
  assign es_pc          = reset ? 32'd0 : r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_es_valid <= 1'b0;
    end else if (flush) begin
      // Flush wins over a simultaneous offer: that instruction is dropped.
      r_es_valid <= 1'b0;
    end else if (es_allowin) begin
      r_es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aluop   <= 4'd0;
      r_src1    <= 32'd0;
      r_src2    <= 32'd0;
      r_md_op   <= 3'd0;
      r_res_sel <= 2'd0;
      r_ov_chk  <= 1'b0;
      r_dest    <= 5'd0;
      r_pc      <= 32'd0;
    end else if (ds_to_es_valid && es_allowin && !flush) begin
      r_aluop   <= ds_aluop;
      r_src1    <= ds_src1;
      r_src2    <= ds_src2;
      r_md_op   <= ds_md_op;
      r_res_sel <= ds_res_sel;
      r_ov_chk  <= ds_ov_chk;
      r_dest    <= ds_dest;
      r_pc      <= ds_pc;
    end
  end

  // ---------------- multiplier ----------------
  assign w_prod_s = $signed({{32{r_src1[31]}}, r_src1}) * $signed({{32{r_src2[31]}}, r_src2});
  assign w_prod_u = {32'd0, r_src1} * {32'd0, r_src2};

`ifdef MYCPU_DIV_EN
  // ---------------- iterative divider ----------------
  localparam logic [2:0] MD_DIV  = 3'd3;
  localparam logic [2:0] MD_DIVU = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  div_state_t  r_state;
  div_state_t  w_state_next;
  logic [4:0]  r_div_cnt;
  logic [31:0] r_div_rem;
  logic [31:0] r_div_quo;   // holds the dividend, shifted out as quotient bits come in
  logic [31:0] r_div_dvs;

  logic        w_is_div;
  logic        w_div_zero;
  logic        w_div_signed;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;

  assign w_is_div     = (r_md_op == MD_DIV) || (r_md_op == MD_DIVU);
  assign w_div_zero   = (r_src2 == 32'd0);
  assign w_div_signed = (r_md_op == MD_DIV);
  assign w_mag1       = (w_div_signed && r_src1[31]) ? (32'd0 - r_src1) : r_src1;
  assign w_mag2       = (w_div_signed && r_src2[31]) ? (32'd0 - r_src2) : r_src2;

  // Restoring step: the partial remainder is always below the divisor, so
  // when the trial subtract succeeds its 32-bit result is exact.
  assign w_shift = {r_div_rem, r_div_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_div_dvs});
  assign w_diff  = w_shift[31:0] - r_div_dvs;

  // Operands stay latched for the whole divide (allowin is low), so the
  // sign fix-up can read them directly.
  assign w_div_q = (w_div_signed && (r_src1[31] ^ r_src2[31])) ? (32'd0 - r_div_quo) : r_div_quo;
  assign w_div_r = (w_div_signed && r_src1[31]) ? (32'd0 - r_div_rem) : r_div_rem;

  // Divide-by-zero bypasses the FSM and finishes immediately.
  assign w_ready_go = ~w_is_div | w_div_zero | (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (r_es_valid && w_is_div && !w_div_zero) w_state_next = S_BUSY;
      S_BUSY: if (r_div_cnt == 5'd31) w_state_next = S_DONE;
      S_DONE: if (w_handshake) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= 5'd0;
      r_div_rem <= 32'd0;
      r_div_quo <= 32'd0;
      r_div_dvs <= 32'd0;
    end else if (r_state == S_IDLE && w_state_next == S_BUSY) begin
      r_div_cnt <= 5'd0;
      r_div_rem <= 32'd0;
      r_div_quo <= w_mag1;
      r_div_dvs <= w_mag2;
    end else if (r_state == S_BUSY && !flush) begin
      r_div_cnt <= r_div_cnt + 5'd1;
      r_div_rem <= w_ge ? w_diff : w_shift[31:0];
      r_div_quo <= {r_div_quo[30:0], w_ge};
    end
  end
`else
  assign w_ready_go = 1'b1;
`endif

  // ---------------- HI/LO ----------------
  // Written only at the handshake edge so a flushed or trapping instruction
  // leaves HI/LO untouched; the next instruction reads the new value directly.
  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (w_handshake && !w_ex) begin
      case (r_md_op)
        MD_MULT: begin
          w_hi_next = w_prod_s[63:32];
          w_lo_next = w_prod_s[31:0];
        end
        MD_MULTU: begin
          w_hi_next = w_prod_u[63:32];
          w_lo_next = w_prod_u[31:0];
        end
        MD_MTHI: w_hi_next = r_src1;
        MD_MTLO: w_lo_next = r_src1;
`ifdef MYCPU_DIV_EN
        MD_DIV, MD_DIVU: begin
          if (!w_div_zero) begin
            w_hi_next = w_div_r;
            w_lo_next = w_div_q;
          end
        end
`endif
        default: begin
          w_hi_next = r_hi;
          w_lo_next = r_lo;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      r_hi <= w_hi_next;
      r_lo <= w_lo_next;
    end
  end

  always_comb begin
    es_result = 32'd0;
    case (r_res_sel)
      2'd0: es_result = w_alu_result;
      2'd1: es_result = r_hi;
      2'd2: es_result = r_lo;
      default: es_result = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_mycpu_exe_stage.sv
`timescale 1ns/1ps
module tb_mycpu_exe_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [3:0]  ds_aluop;
  logic [31:0] ds_src1;
  logic [31:0] ds_src2;
  logic [2:0]  ds_md_op;
  logic [1:0]  ds_res_sel;
  logic        ds_ov_chk;
  logic [4:0]  ds_dest;
  logic [31:0] ds_pc;
  logic        flush;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic [31:0] es_pc;
  logic        es_ex;

  always #5 clk = ~clk;

  mycpu_exe_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allowin     (es_allowin),
    .ds_aluop       (ds_aluop),
    .ds_src1        (ds_src1),
    .ds_src2        (ds_src2),
    .ds_md_op       (ds_md_op),
    .ds_res_sel     (ds_res_sel),
    .ds_ov_chk      (ds_ov_chk),
    .ds_dest        (ds_dest),
    .ds_pc          (ds_pc),
    .flush          (flush),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_result      (es_result),
    .es_dest        (es_dest),
    .es_pc          (es_pc),
    .es_ex          (es_ex)
  );

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1;
  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;
  localparam logic [1:0] R_ALU = 2'd0, R_HI = 2'd1, R_LO = 2'd2, R_ZERO = 2'd3;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        ex;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_n    = 0;
  int          last_pop_cyc = -1;
  int          waits;
  int          start;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic        last_allowin, last_to_ms, last_ex;
  logic [4:0]  last_dest;
  logic [31:0] last_pc, last_result;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: sample outputs at the falling edge, score any handshake,
  // then return just after the rising edge so inputs can change.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    last_allowin = es_allowin;
    last_to_ms   = es_to_ms_valid;
    last_ex      = es_ex;
    last_dest    = es_dest;
    last_pc      = es_pc;
    last_result  = es_result;
    if (es_to_ms_valid && ms_allowin) begin
      n_checks++;
      assert (sb.size() > 0) n_pass++;
      else $error("FAIL unexpected_output observed=pc %h expected=no output", es_pc);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn pc=%h result=%h dest=%0d ex=%b cycle=%0d", es_pc, es_result, es_dest, es_ex, cyc_n);
        check($sformatf("result@%h", e.pc), es_result, e.result);
        check($sformatf("dest@%h", e.pc), {27'd0, es_dest}, {27'd0, e.dest});
        check($sformatf("ex@%h", e.pc), {31'd0, es_ex}, {31'd0, e.ex});
        check($sformatf("pc@%h", e.pc), es_pc, e.pc);
        last_pop_cyc = cyc_n;
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and hold it until the stage accepts it.
  task automatic issue(input logic [3:0] aluop, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [2:0] md, input logic [1:0] rs, input logic ov,
                       input logic [4:0] dest, input bit push,
                       input logic [31:0] exp_res, input logic [4:0] exp_dest, input logic exp_ex);
    exp_t e;
    ds_aluop = aluop; ds_src1 = s1; ds_src2 = s2; ds_md_op = md;
    ds_res_sel = rs; ds_ov_chk = ov; ds_dest = dest; ds_pc = pc_ctr;
    ds_to_es_valid = 1'b1;
    if (push) begin
      e.result = exp_res; e.dest = exp_dest; e.ex = exp_ex; e.pc = pc_ctr;
      sb.push_back(e);
    end
    pc_ctr = pc_ctr + 32'd4;
    waits = 0;
    while (1) begin
      cyc();
      if (last_allowin) break;
      waits++;
      if (waits > 200) begin
        n_checks++;
        $error("FAIL accept_timeout observed=%0d cycles expected=accept", waits);
        break;
      end
    end
    ds_to_es_valid = 1'b0;
  endtask

  task automatic op(input logic [3:0] aluop, input logic [31:0] s1, input logic [31:0] s2,
                    input logic [2:0] md, input logic [1:0] rs, input logic ov, input logic [4:0] dest,
                    input logic [31:0] exp_res, input logic [4:0] exp_dest, input logic exp_ex);
    issue(aluop, s1, s2, md, rs, ov, dest, 1'b1, exp_res, exp_dest, exp_ex);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; ms_allowin = 1'b1;
    ds_aluop = 4'd0; ds_src1 = 32'd0; ds_src2 = 32'd0; ds_md_op = 3'd0;
    ds_res_sel = 2'd0; ds_ov_chk = 1'b0; ds_dest = 5'd9; ds_pc = 32'hDEAD_0000;
    ds_to_es_valid = 1'b1;   // offered during reset; must not be taken
    repeat (3) @(posedge clk);
    #1;
    cyc();
    check("rst_to_ms_valid", {31'd0, last_to_ms}, 32'd0);
    check("rst_ex", {31'd0, last_ex}, 32'd0);
    check("rst_dest", {27'd0, last_dest}, 32'd0);
    check("rst_pc", last_pc, 32'd0);
    reset = 1'b0; ds_to_es_valid = 1'b0;
    cyc();
    check("post_rst_allowin", {31'd0, last_allowin}, 32'd1);
    check("post_rst_to_ms_valid", {31'd0, last_to_ms}, 32'd0);

    // ALU and overflow
    op(ADD, 32'h7FFF_FFFF, 32'd1, NONE, R_ALU, 1'b1, 5'd2, 32'h8000_0000, 5'd0, 1'b1);
    op(ADD, 32'd5, 32'd7, NONE, R_ALU, 1'b1, 5'd3, 32'd12, 5'd3, 1'b0);
    check("add_no_stall", waits, 0);
    op(SUB, 32'd3, 32'd5, NONE, R_ALU, 1'b1, 5'd4, 32'hFFFF_FFFE, 5'd4, 1'b0);
    op(SUB, 32'h8000_0000, 32'd1, NONE, R_ALU, 1'b1, 5'd5, 32'h7FFF_FFFF, 5'd0, 1'b1);
    op(ADD, 32'h7FFF_FFFF, 32'd1, NONE, R_ALU, 1'b0, 5'd6, 32'h8000_0000, 5'd6, 1'b0);

    // MULT / MULTU with immediate MFHI / MFLO
    op(ADD, 32'hFFFF_FFFE, 32'd3, MULT, R_ALU, 1'b0, 5'd0, 32'd1, 5'd0, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 1'b0);
    check("mfhi_no_stall", waits, 0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'hFFFF_FFFA, 5'd8, 1'b0);
    check("mflo_no_stall", waits, 0);
    op(ADD, 32'hFFFF_FFFF, 32'd2, MULTU, R_ALU, 1'b0, 5'd0, 32'd1, 5'd0, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'd1, 5'd7, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'hFFFF_FFFE, 5'd8, 1'b0);

    // MTHI / MTLO, and a trapping MTHI that must not write HI
    op(ADD, 32'h1234_5678, 32'd0, MTHI, R_ALU, 1'b0, 5'd0, 32'h1234_5678, 5'd0, 1'b0);
    op(ADD, 32'h9ABC_DEF0, 32'd0, MTLO, R_ALU, 1'b0, 5'd0, 32'h9ABC_DEF0, 5'd0, 1'b0);
    op(ADD, 32'h7FFF_FFFF, 32'd1, MTHI, R_ALU, 1'b1, 5'd0, 32'h8000_0000, 5'd0, 1'b1);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'h9ABC_DEF0, 5'd8, 1'b0);
    op(ADD, 32'd1, 32'd2, NONE, R_ZERO, 1'b0, 5'd9, 32'd0, 5'd9, 1'b0);

    // Flush an MTHI while a new MTLO is offered in the same cycle
    issue(ADD, 32'hDEAD_BEEF, 32'd0, MTHI, R_ALU, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    flush = 1'b1; ds_to_es_valid = 1'b1; ds_md_op = MTLO; ds_src1 = 32'h0BAD_F00D; ds_pc = 32'hBAD0_0000;
    cyc();
    check("flush_to_ms_valid", {31'd0, last_to_ms}, 32'd0);
    flush = 1'b0; ds_to_es_valid = 1'b0;
    cyc();
    check("flush_dropped_valid", {31'd0, last_to_ms}, 32'd0);
    check("flush_allowin", {31'd0, last_allowin}, 32'd1);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'h9ABC_DEF0, 5'd8, 1'b0);

`ifndef MYCPU_DIV_EN
    // Without the divider DIV/DIVU are single-cycle no-ops
    op(ADD, 32'd7, 32'd2, DIV, R_ALU, 1'b0, 5'd0, 32'd9, 5'd0, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'h9ABC_DEF0, 5'd8, 1'b0);
    check("nodiv_no_stall", waits, 0);
    op(ADD, 32'd100, 32'd7, DIVU, R_ALU, 1'b0, 5'd0, 32'd107, 5'd0, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 1'b0);
    check("nodivu_no_stall", waits, 0);
    issue(ADD, 32'd100, 32'd7, DIV, R_ALU, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
`else
    // DIV -7 / 2: 33-cycle latency
    op(ADD, 32'hFFFF_FFF9, 32'd2, DIV, R_ALU, 1'b0, 5'd0, 32'hFFFF_FFFB, 5'd0, 1'b0);
    start = cyc_n;
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'hFFFF_FFFD, 5'd8, 1'b0);
    check("div_allowin_low_cycles", waits, 33);
    check("div_handoff_cycle", last_pop_cyc - start, 33);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 1'b0);

    // DIVU 100 / 7 with backpressure in cycles 33-35
    op(ADD, 32'd100, 32'd7, DIVU, R_ALU, 1'b0, 5'd0, 32'd107, 5'd0, 1'b0);
    start = cyc_n;
    for (int k = 0; k <= 36; k++) begin
      ms_allowin = (k < 33 || k > 35);
      cyc();
      if (k >= 33 && k <= 35) begin
        check($sformatf("divu_hold_valid_c%0d", k), {31'd0, last_to_ms}, 32'd1);
        check($sformatf("divu_hold_result_c%0d", k), last_result, 32'd107);
      end
    end
    ms_allowin = 1'b1;
    check("divu_handoff_cycle", last_pop_cyc - start, 36);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'd2, 5'd7, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'd14, 5'd8, 1'b0);

    // Most-negative / -1
    op(ADD, 32'h8000_0000, 32'hFFFF_FFFF, DIV, R_ALU, 1'b0, 5'd0, 32'h7FFF_FFFF, 5'd0, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'h8000_0000, 5'd8, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'd0, 5'd7, 1'b0);

    // Divide by zero: single cycle, HI/LO untouched
    op(ADD, 32'd5, 32'd0, DIV, R_ALU, 1'b0, 5'd0, 32'd5, 5'd0, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'h8000_0000, 5'd8, 1'b0);
    check("div0_no_stall", waits, 0);

    // Flush a divide at cycle 10
    issue(ADD, 32'd53, 32'd5, DIV, R_ALU, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    repeat (10) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'h8000_0000, 5'd8, 1'b0);
    check("div_flush_accept_next", waits, 0);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'd0, 5'd7, 1'b0);

    // Reset in the middle of a divide
    issue(ADD, 32'd100, 32'd7, DIV, R_ALU, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    repeat (5) cyc();
`endif
    reset = 1'b1;
    cyc();
    check("midrst_to_ms_valid", {31'd0, last_to_ms}, 32'd0);
    check("midrst_ex", {31'd0, last_ex}, 32'd0);
    check("midrst_dest", {27'd0, last_dest}, 32'd0);
    check("midrst_pc", last_pc, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    check("midrst_allowin_after", {31'd0, last_allowin}, 32'd1);
    op(ADD, 32'd0, 32'd0, NONE, R_HI, 1'b0, 5'd7, 32'd0, 5'd7, 1'b0);
    op(ADD, 32'd0, 32'd0, NONE, R_LO, 1'b0, 5'd8, 32'd0, 5'd8, 1'b0);

    repeat (3) cyc();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mycpu_exe_stage.md
MYCPU_EXE_STAGE -- requirements
Module: myCPU_exe_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 SHALL have ports (name  dir  width  meaning):
- clk  in  1  clock
- reset  in  1  sync reset
- ds_to_es_valid  in  1  decode offers an instruction
- es_allowin  out  1  stage accepts an instruction
- ds_aluop  in  4  opcode forwarded to myCPU_alu
- ds_src1, ds_src2  in  32  operands (A, B)
- ds_md_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
- ds_res_sel  in  2  00 ALU, 01 HI, 10 LO
- ds_ov_chk  in  1  overflow traps (ADD/ADDI/SUB)
- ds_dest  in  5  destination register
- ds_pc  in  32  instruction PC
- flush  in  1  kill the instruction in EX
- ms_allowin  in  1  memory stage accepts
- es_to_ms_valid  out  1  result offered downstream
- es_result  out  32  selected result
- es_dest  out  5  destination; 0 when no writeback
- es_pc  out  32  PC of the instruction in EX
- es_ex  out  1  overflow exception flag

Function
REQ-003 SHALL hold one instruction in registers with valid bit es_valid.
REQ-004 SHALL compute es_allowin = !es_valid | (es_ready_go & ms_allowin), and es_to_ms_valid = es_valid & es_ready_go & !flush.
REQ-005 SHALL latch all ds_* inputs on a cycle with ds_to_es_valid & es_allowin, and SHALL load es_valid <= ds_to_es_valid on any cycle with es_allowin.
REQ-006 SHALL instantiate myCPU_alu with the latched aluop/src1/src2, using aluResult and overFlow.
REQ-007 SHALL drive es_ex = es_valid & ov_chk & overFlow; when es_ex is high, es_dest SHALL be 0 and HI/LO SHALL NOT be written.
REQ-008 SHALL drive es_result as follows: res_sel 00 gives aluResult, 01 gives HI, 10 gives LO, 11 gives 0.
REQ-009 SHALL commit HI/LO writes only at the handshake edge (es_to_ms_valid & ms_allowin):
- MULT: signed 64-bit product.
- MULTU: unsigned 64-bit product.
- HI takes product[63:32]; LO takes product[31:0].
- MTHI/MTLO: write src1.
REQ-010 SHALL use es_ready_go = 1 for all non-divide operations.
REQ-011 SHALL implement the DIV/DIVU FSM as IDLE -> BUSY -> DONE:
- IDLE -> BUSY when es_valid, md_op is DIV/DIVU and divisor != 0.
- BUSY runs a restoring divide of 32 iterations on the operand magnitudes.
- BUSY -> DONE after the 32nd iteration.
- DONE -> IDLE at the handshake edge.
- es_ready_go = (state == DONE).
REQ-012 SHALL drive es_to_ms_valid first 33 cycles after the divide enters EX (cycle 0) when ms_allowin is held high.
REQ-013 SHALL form signed results with quotient sign = sign(src1) ^ sign(src2) and remainder sign = sign(src1); 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-014 SHALL write LO=quotient and HI=remainder.
REQ-015 SHALL treat divisor 0 as a 1-cycle no-op with HI/LO unchanged.
REQ-016 SHALL on flush: clear es_valid at the next edge, return the FSM to IDLE, write nothing to HI/LO, and hold es_to_ms_valid low in the flush cycle.
REQ-017 SHALL give flush priority over a simultaneous ds_to_es_valid in the same cycle; the offered instruction is dropped.
REQ-018 SHALL make HI/LO written by instruction N visible to MFHI/MFLO in N+1 with no stall.

Reset
REQ-019 SHALL on reset clear es_valid, HI, LO, all latched fields and the divide counter, and set the FSM to IDLE.
REQ-020 SHALL hold es_to_ms_valid=0, es_ex=0, es_dest=0 and es_pc=0 during reset; es_allowin SHALL be 1 in the first cycle after reset.
REQ-021 SHALL abandon a divide if reset occurs mid-operation; no HI/LO write occurs.

Configuration
REQ-022 SHALL compile the iterative divider only when MYCPU_DIV_EN is defined.
REQ-023 SHALL, without MYCPU_DIV_EN, complete DIV/DIVU as 1-cycle no-ops (HI/LO unchanged, es_ready_go=1) and contain no divider logic.

Verification
REQ-024 ADD src1=0x7FFFFFFF, src2=1, ov_chk=1 -> es_ex=1, es_dest=0, 1-cycle handoff.
REQ-025 MULT 0xFFFFFFFE x 3, then MFHI, then MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; back-to-back with no stall.
REQ-026 DIV -7 / 2 (MYCPU_DIV_EN) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; es_to_ms_valid at cycle 33; es_allowin low from cycle 0 to cycle 32.
REQ-027 DIVU 100/7, ms_allowin low in cycles 33-35 -> DONE held, es_result stable, HI/LO (2/14) written only at the cycle-36 handshake.
REQ-028 DIV issued, flush at cycle 10 -> FSM IDLE at cycle 11, HI/LO unchanged, the next instruction accepted at cycle 11.
REQ-029 Reset asserted mid-divide -> all outputs 0, es_allowin=1 in the cycle after reset deasserts, HI=LO=0.
